// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with r0 hardwired to zero and a busy scoreboard
// Optional same-cycle write-to-read bypass: define REGFILE_MP_BYPASS_EN
module regfile_mp #(
  parameter  int WORD = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*WORD-1:0]   q,
  output logic [NRD-1:0]        hz,
  input  logic                  we0,
  input  logic [AW-1:0]         waddr0,
  input  logic [WORD-1:0]       wdata0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr1,
  input  logic [WORD-1:0]       wdata1,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_addr,
  output logic                  issue_stall,
  output logic [NREG-1:0]       busy
);

  logic [WORD-1:0] regbank_q [1:NREG-1];
  logic [WORD-1:0] regbank_d [1:NREG-1];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            wr0_en;
  logic            wr1_en;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic            issue_acc;

  assign wr0_en = we0 && (waddr0 != '0);
  assign wr1_en = we1 && (waddr1 != '0);

  // One-hot view of which registers are written this cycle; bit 0 never set.
  always_comb begin
    clr_vec = '0;
    if (wr0_en) clr_vec[waddr0] = 1'b1;
    if (wr1_en) clr_vec[waddr1] = 1'b1;
    clr_vec[0] = 1'b0;
  end

  always_comb begin
    issue_stall = issue_valid && (issue_addr != '0) &&
                  busy_q[issue_addr] && !clr_vec[issue_addr];
    issue_acc   = issue_valid && !issue_stall && (issue_addr != '0);
  end

  // Set beats clear when an accepted issue and a writeback target the same register.
  always_comb begin
    set_vec = '0;
    if (issue_acc) set_vec[issue_addr] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // Port 1 is applied first so port 0 overwrites it on an address collision.
  always_comb begin
    regbank_d = regbank_q;
    if (wr1_en) regbank_d[waddr1] = wdata1;
    if (wr0_en) regbank_d[waddr0] = wdata0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 1; r < NREG; r++) regbank_q[r] <= '0;
      busy_q <= '0;
    end else begin
      regbank_q <= regbank_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    q  = '0;
    hz = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = ra[i*AW +: AW];
      if (a != '0) begin
`ifdef REGFILE_MP_BYPASS_EN
        if (wr0_en && (waddr0 == a))      q[i*WORD +: WORD] = wdata0;
        else if (wr1_en && (waddr1 == a)) q[i*WORD +: WORD] = wdata1;
        else                              q[i*WORD +: WORD] = regbank_q[a];
        hz[i] = busy_q[a] && !clr_vec[a];
`else
        q[i*WORD +: WORD] = regbank_q[a];
        hz[i] = busy_q[a];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against an array/bit model
module tb_regfile_mp;
  localparam int WORD = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rstn;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*WORD-1:0] q;
  logic [NRD-1:0]      hz;
  logic                we0, we1;
  logic [AW-1:0]       waddr0, waddr1;
  logic [WORD-1:0]     wdata0, wdata1;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                issue_stall;
  logic [NREG-1:0]     busy;

  always #5 clk = ~clk;

  regfile_mp #(.WORD(WORD), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rstn(rstn), .ra(ra), .q(q), .hz(hz),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_stall(issue_stall), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  logic [WORD-1:0] mem [NREG];
  bit              sb  [NREG];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit written(input logic [AW-1:0] a);
    return (a != 0) && ((we0 && waddr0 == a) || (we1 && waddr1 == a));
  endfunction

  function automatic logic [WORD-1:0] exp_q(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && we0 && waddr0 == a) return wdata0;
    if (BYP && we1 && waddr1 == a) return wdata1;
    return mem[a];
  endfunction

  function automatic bit exp_stall();
    return issue_valid && issue_addr != 0 && sb[issue_addr] && !written(issue_addr);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      mem[r] = '0;
      sb[r]  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [NREG-1:0] eb;
    #1;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = ra[i*AW +: AW];
      check_eq($sformatf("q%0d", i), q[i*WORD +: WORD], exp_q(a));
      check_eq($sformatf("hz%0d", i), hz[i], (a != 0) && sb[a] && !(BYP && written(a)));
    end
    check_eq("issue_stall", issue_stall, exp_stall());
    for (int r = 0; r < NREG; r++) eb[r] = sb[r];
    check_eq("busy", busy, eb);
  endtask

  // Inputs are stable across the edge, so the model reads them right after it.
  task automatic model_edge();
    bit acc;
    acc = issue_valid && !exp_stall() && issue_addr != 0;
    if (we0 && waddr0 != 0) sb[waddr0] = 1'b0;
    if (we1 && waddr1 != 0) sb[waddr1] = 1'b0;
    if (acc) sb[issue_addr] = 1'b1;
    if (we1 && waddr1 != 0) mem[waddr1] = wdata1;
    if (we0 && waddr0 != 0) mem[waddr0] = wdata0;
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    issue_valid = 0; issue_addr = 0; ra = '0;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    model_reset();
    ra = {5'd0, 5'd5};
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_q0", q[31:0], 32'h0);
    check_eq("reset_q1", q[63:32], 32'h0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_hz", hz, 0);
    check_eq("reset_stall", issue_stall, 0);
    @(negedge clk);
    rstn = 1'b1;

    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    tick();
    idle(); ra = {5'd0, 5'd5};
    #1 check_eq("r5_readback", q[31:0], 32'hDEADBEEF);
    tick();

    we0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
    issue_valid = 1; issue_addr = 0; ra = '0;
    #1 check_eq("r0_stall", issue_stall, 0);
    tick();
    idle();
    #1 check_eq("r0_q", q[31:0], 32'h0);
    check_eq("r0_busy", busy, 0);
    tick();

    we0 = 1; waddr0 = 7; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 7; wdata1 = 32'h22222222;
    tick();
    idle(); ra = {5'd0, 5'd7};
    #1 check_eq("collision_r7", q[31:0], 32'h11111111);
    tick();

    issue_valid = 1; issue_addr = 3;
    tick();
    idle(); ra = {5'd0, 5'd3};
    #1 check_eq("raw_hz_set", hz[0], 1);
    tick();
    ra = {5'd0, 5'd3}; we1 = 1; waddr1 = 3; wdata1 = 32'hA5;
    #1 check_eq("raw_hz_wr", hz[0], BYP ? 1'b0 : 1'b1);
    check_eq("raw_q_wr", q[31:0], BYP ? 32'hA5 : 32'h0);
    tick();
    idle(); ra = {5'd0, 5'd3};
    #1 check_eq("raw_q_next", q[31:0], 32'hA5);
    check_eq("raw_hz_next", hz[0], 0);
    tick();

    issue_valid = 1; issue_addr = 9;
    tick();
    #1 check_eq("waw_stall", issue_stall, 1);
    tick();
    #1 check_eq("waw_busy_kept", busy[9], 1);
    we0 = 1; waddr0 = 9; wdata0 = 32'h99;
    #1 check_eq("waw_stall_clr", issue_stall, 0);
    tick();
    idle();
    #1 check_eq("waw_set_wins", busy[9], 1);
    tick();

    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      waddr0 = AW'($urandom_range(0, 11));
      waddr1 = AW'($urandom_range(0, 11));
      wdata0 = $urandom;
      wdata1 = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = AW'($urandom_range(0, 11));
      for (int i = 0; i < NRD; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) waddr0 = waddr1;
      tick();
    end

    idle();
    we0 = 1; waddr0 = 4; wdata0 = 32'h1234;
    tick();
    idle(); issue_valid = 1; issue_addr = 4;
    tick();
    idle(); ra = {5'd0, 5'd4};
    #1 check_eq("pre_rst_q", q[31:0], 32'h1234);
    check_eq("pre_rst_busy", busy[4], 1);
    #2 rstn = 1'b0;
    #1 check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_q", q[31:0], 32'h0);
    check_eq("async_rst_hz", hz, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
